// File: rtl/execute_issue_controller.sv
// Issue-stage controller: one-entry issue register between decode and the
// execution unit, with a per-register busy scoreboard that stalls on RAW and
// WAW hazards against in-flight results. Writeback clears busy bits and
// bypasses the scoreboard in the same cycle; flush drops the held instruction.
module execute_issue_controller #(
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int INSTR_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_instruction,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_uses_rs1,
  input  logic                  in_uses_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_writes_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INSTR_W-1:0]    out_instruction,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_writes_rd,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  flush,
  output logic [REG_COUNT-1:0]  busy,
  output logic [31:0]           stall_count
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = {REG_ADDR_W{1'b0}};

  logic [REG_COUNT-1:0]  busy_r;
  logic                  out_valid_r;
  logic [INSTR_W-1:0]    out_instruction_r;
  logic [REG_ADDR_W-1:0] out_rs1_r;
  logic [REG_ADDR_W-1:0] out_rs2_r;
  logic [REG_ADDR_W-1:0] out_rd_r;
  logic                  out_writes_rd_r;
  logic [31:0]           stall_count_r;

  logic [REG_COUNT-1:0]  wb_clr_s;
  logic [REG_COUNT-1:0]  flush_clr_s;
  logic [REG_COUNT-1:0]  set_s;
  logic [REG_COUNT-1:0]  eff_busy_s;
  logic [REG_COUNT-1:0]  busy_nxt_s;
  logic                  hazard_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  stall_inc_s;
  logic                  out_valid_nxt_s;

  // Writeback clear mask; also forms the same-cycle bypass view of the scoreboard.
  always_comb begin
    wb_clr_s = {REG_COUNT{1'b0}};
    if (wb_valid) begin
      wb_clr_s[wb_rd] = 1'b1;
    end else begin
      wb_clr_s = {REG_COUNT{1'b0}};
    end
    eff_busy_s = busy_r & ~wb_clr_s;
  end

  // Hazard detection against effective busy; x0 never matches.
  always_comb begin
    hazard_s = (in_uses_rs1  & (in_rs1 != ZERO_IDX) & eff_busy_s[in_rs1]) |
               (in_uses_rs2  & (in_rs2 != ZERO_IDX) & eff_busy_s[in_rs2]) |
               (in_writes_rd & (in_rd  != ZERO_IDX) & eff_busy_s[in_rd]);
    in_ready_s  = ~flush & ~hazard_s & (~out_valid_r | out_ready);
    accept_s    = in_valid & in_ready_s;
    stall_inc_s = in_valid & hazard_s & ~flush;
  end

  // Scoreboard next state: writeback and flush clear, accept sets and wins.
  always_comb begin
    flush_clr_s = {REG_COUNT{1'b0}};
    set_s       = {REG_COUNT{1'b0}};
    if (flush && out_valid_r && out_writes_rd_r && (out_rd_r != ZERO_IDX)) begin
      flush_clr_s[out_rd_r] = 1'b1;
    end else begin
      flush_clr_s = {REG_COUNT{1'b0}};
    end
    if (accept_s && in_writes_rd && (in_rd != ZERO_IDX)) begin
      set_s[in_rd] = 1'b1;
    end else begin
      set_s = {REG_COUNT{1'b0}};
    end
    busy_nxt_s = (busy_r & ~wb_clr_s & ~flush_clr_s) | set_s;
  end

  // Issue register occupancy: EMPTY/FULL transitions.
  always_comb begin
    if (flush) begin
      out_valid_nxt_s = 1'b0;
    end else if (accept_s) begin
      out_valid_nxt_s = 1'b1;
    end else if (out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // State update: scoreboard, issue register, stall counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_r            <= {REG_COUNT{1'b0}};
      out_valid_r       <= 1'b0;
      out_instruction_r <= {INSTR_W{1'b0}};
      out_rs1_r         <= ZERO_IDX;
      out_rs2_r         <= ZERO_IDX;
      out_rd_r          <= ZERO_IDX;
      out_writes_rd_r   <= 1'b0;
      stall_count_r     <= 32'd0;
    end else begin
      busy_r      <= busy_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      if (accept_s) begin
        out_instruction_r <= in_instruction;
        out_rs1_r         <= in_rs1;
        out_rs2_r         <= in_rs2;
        out_rd_r          <= in_rd;
        out_writes_rd_r   <= in_writes_rd;
      end
      if (stall_inc_s) begin
        stall_count_r <= stall_count_r + 32'd1;
      end
    end
  end

  assign in_ready        = in_ready_s;
  assign out_valid       = out_valid_r;
  assign out_instruction = out_instruction_r;
  assign out_rs1         = out_rs1_r;
  assign out_rs2         = out_rs2_r;
  assign out_rd          = out_rd_r;
  assign out_writes_rd   = out_writes_rd_r;
  assign busy            = busy_r;
  assign stall_count     = stall_count_r;

endmodule

// File: tb/tb_execute_issue_controller.sv
// Directed bench for execute_issue_controller: reset, streaming, RAW stall
// with writeback bypass, WAW and x0, backpressure, and flush.
module tb_execute_issue_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_writes_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_writes_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] busy;
  logic [31:0] stall_count;

  int tests = 0;
  int fails = 0;

  execute_issue_controller dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_rd(in_rd), .in_writes_rd(in_writes_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_writes_rd(out_writes_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy(busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then read 1 time unit later.
  task step();
    @(posedge clk);
    #1;
  endtask

  task idle_inputs();
    in_valid = 1'b0; in_instruction = 32'd0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_writes_rd = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
  endtask

  task set_in(input logic [31:0] ins, input logic [4:0] rd, input logic wr,
              input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
    in_valid = 1'b1; in_instruction = ins;
    in_rd = rd; in_writes_rd = wr;
    in_rs1 = rs1; in_uses_rs1 = u1;
    in_rs2 = rs2; in_uses_rs2 = u2;
  endtask

  task apply_reset();
    idle_inputs();
    out_ready = 1'b1;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task test_reset();
    reset_n = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    set_in(32'hDEADBEEF, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    tests++; if (busy !== 32'h0) begin fails++; $display("FAIL reset_busy got=%h exp=00000000", busy); end
    tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
    tests++; if (out_instruction !== 32'h0 || out_rd !== 5'd0) begin
      fails++; $display("FAIL reset_payload got=%h/%0d exp=0/0", out_instruction, out_rd); end
    idle_inputs();
    reset_n = 1'b1;
  endtask

  task test_stream();
    apply_reset();
    set_in(32'h00100093, 5'd1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready1 got=%0b exp=1", in_ready); end
    step();
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd1) begin
      fails++; $display("FAIL stream_out1 got=%0b/%0d exp=1/1", out_valid, out_rd); end
    set_in(32'h00200113, 5'd2, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready2 got=%0b exp=1", in_ready); end
    step();
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd2) begin
      fails++; $display("FAIL stream_out2 got=%0b/%0d exp=1/2", out_valid, out_rd); end
    set_in(32'h00300193, 5'd3, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    step();
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_instruction !== 32'h00300193) begin
      fails++; $display("FAIL stream_out3 got=%0b/%0d/%h exp=1/3/00300193", out_valid, out_rd, out_instruction); end
    tests++; if (busy !== 32'h0000000E) begin fails++; $display("FAIL stream_busy got=%h exp=0000000e", busy); end
    idle_inputs();
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got=%0b exp=0", out_valid); end
  endtask

  task test_raw_bypass();
    apply_reset();
    set_in(32'h002082B3, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
    step();
    tests++; if (busy !== 32'h00000020) begin fails++; $display("FAIL raw_busy5 got=%h exp=00000020", busy); end
    set_in(32'h40128333, 5'd6, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1);
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL raw_stall_ready got=%0b exp=0", in_ready); end
    step();
    tests++; if (stall_count !== 32'd1) begin fails++; $display("FAIL raw_stall1 got=%0d exp=1", stall_count); end
    step();
    tests++; if (stall_count !== 32'd2) begin fails++; $display("FAIL raw_stall2 got=%0d exp=2", stall_count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL raw_empty got=%0b exp=0", out_valid); end
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL raw_bypass_ready got=%0b exp=1", in_ready); end
    step();
    tests++; if (busy !== 32'h00000040) begin fails++; $display("FAIL raw_busy_after got=%h exp=00000040", busy); end
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd6 || out_rs1 !== 5'd5 || out_rs2 !== 5'd1) begin
      fails++; $display("FAIL raw_issue got=%0b/%0d/%0d/%0d exp=1/6/5/1", out_valid, out_rd, out_rs1, out_rs2); end
    tests++; if (stall_count !== 32'd2) begin fails++; $display("FAIL raw_stall_final got=%0d exp=2", stall_count); end
    idle_inputs();
  endtask

  task test_waw_x0();
    apply_reset();
    set_in(32'h00000393, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_in(32'h00100393, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL waw_ready got=%0b exp=0", in_ready); end
    step();
    tests++; if (stall_count !== 32'd1 || busy !== 32'h00000080) begin
      fails++; $display("FAIL waw_state got=%0d/%h exp=1/00000080", stall_count, busy); end
    set_in(32'h00000013, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL x0_ready got=%0b exp=1", in_ready); end
    step();
    tests++; if (busy !== 32'h00000080 || out_rd !== 5'd0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL x0_state got=%h/%0d/%0b exp=00000080/0/1", busy, out_rd, out_valid); end
    tests++; if (stall_count !== 32'd1) begin fails++; $display("FAIL x0_stall got=%0d exp=1", stall_count); end
    idle_inputs();
  endtask

  task test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    set_in(32'hAAAA0001, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_in(32'hBBBB0002, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready%0d got=%0b exp=0", i, in_ready); end
      tests++; if (out_valid !== 1'b1 || out_instruction !== 32'hAAAA0001 || out_rd !== 5'd9) begin
        fails++; $display("FAIL bp_hold%0d got=%0b/%h/%0d exp=1/aaaa0001/9", i, out_valid, out_instruction, out_rd); end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
    step();
    tests++; if (out_instruction !== 32'hBBBB0002 || out_rd !== 5'd10 || busy !== 32'h00000600) begin
      fails++; $display("FAIL bp_next got=%h/%0d/%h exp=bbbb0002/10/00000600", out_instruction, out_rd, busy); end
    tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL bp_stall got=%0d exp=0", stall_count); end
    idle_inputs();
  endtask

  task test_flush();
    apply_reset();
    set_in(32'h00000193, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_in(32'h00000493, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    tests++; if (busy !== 32'h00000208 || out_rd !== 5'd9 || out_valid !== 1'b1) begin
      fails++; $display("FAIL flush_pre got=%h/%0d/%0b exp=00000208/9/1", busy, out_rd, out_valid); end
    out_ready = 1'b0;
    set_in(32'h00000593, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got=%0b exp=0", in_ready); end
    step();
    idle_inputs();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    tests++; if (busy !== 32'h0) begin fails++; $display("FAIL flush_busy got=%h exp=00000000", busy); end
    tests++; if (out_rd === 5'd11 || stall_count !== 32'd0) begin
      fails++; $display("FAIL flush_noaccept got=%0d/%0d exp=not11/0", out_rd, stall_count); end
    out_ready = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_stream();
    test_raw_bypass();
    test_waw_x0();
    test_backpressure();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execute_issue_controller.md
# execute_issue_controller

Issue-stage controller that sequences decoded instructions into the execution unit. It holds a one-entry issue register and a per-register busy scoreboard, and stalls on read-after-write and write-after-write hazards against in-flight results. Busy bits clear from the writeback port, and `flush` discards the held instruction. It sits between decode and the `execution_unit` operand fetch, and replaces the unconditional decode→execute path.

## Interface
- `REG_COUNT`, default 32: number of architectural registers; register 0 is hard-wired zero and never marked busy.
- `REG_ADDR_W`, default 5: register index width, equal to $clog2(REG_COUNT).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: decode presents an instruction.
- `in_ready` output 1: controller accepts the instruction this cycle (combinational).
- `in_instruction` input $bits(instruction_t): decoded instruction payload, passed through unmodified.
- `in_rs1`, `in_rs2` input REG_ADDR_W: source register indices.
- `in_uses_rs1`, `in_uses_rs2` input 1: source is actually read.
- `in_rd` input REG_ADDR_W: destination index.
- `in_writes_rd` input 1: instruction writes `in_rd`.
- `out_valid` output 1: issue register holds an instruction for the execution unit.
- `out_ready` input 1: execution unit consumes the instruction this cycle.
- `out_instruction`, `out_rs1`, `out_rs2`, `out_rd`, `out_writes_rd` output: registered copies of the accepted fields.
- `wb_valid` input 1: writeback retires a result this cycle.
- `wb_rd` input REG_ADDR_W: register being written back.
- `flush` input 1: discard the held instruction; accept nothing this cycle.
- `busy` output REG_COUNT: scoreboard vector (bit i set means register i has a pending write).
- `stall_count` output 32: hazard-stall cycle counter.

## Operation
- Effective busy for register r: `busy[r] & ~(wb_valid & wb_rd == r)`. A same-cycle writeback bypasses the scoreboard; the register file must be write-through.
- `hazard` is asserted when any of the following holds against effective busy:
  - `in_uses_rs1` and rs1 is busy;
  - `in_uses_rs2` and rs2 is busy;
  - `in_writes_rd` and rd is busy (WAW).
- Index 0 never causes a hazard.
- `in_ready = ~flush & ~hazard & (~out_valid | out_ready)`.
- Accept means `in_valid & in_ready`. On accept:
  - the issue register loads all in_* fields;
  - `out_valid` is 1 next cycle;
  - if `in_writes_rd` and `in_rd != 0`, then `busy[in_rd]` is set.
- Consumed without a new accept (`out_valid & out_ready` only): `out_valid` is 0 next cycle. The payload may hold its stale value.
- Writeback: when `wb_valid`, `busy[wb_rd]` is cleared. If the same index is set by an accept in the same cycle, set wins.
- Flush:
  - `out_valid` is 0 next cycle.
  - If `out_valid & out_writes_rd & out_rd != 0`, clear `busy[out_rd]`. This is safe because WAW stalling guarantees a single pending writer per register.
  - Busy bits of instructions already consumed by the execution unit are untouched; they clear via writeback.
  - `flush` while `out_ready` is high: the instruction counts as consumed and its busy bit is still cleared.
- `stall_count` increments by 1 on every cycle with `in_valid & hazard & ~flush`, and wraps 0xFFFFFFFF→0.
- The block has no explicit FSM. The issue register is either EMPTY (`out_valid=0`) or FULL (`out_valid=1`):
  - EMPTY→FULL on accept;
  - FULL→FULL on consume+accept, or on hold (`~out_ready`);
  - FULL→EMPTY on consume without accept, or on flush.

## Timing
- Reset (reset_n=0 at a rising edge): `out_valid=0`, `busy=0`, `stall_count=0`, all out_* payload fields 0. Reset mid-operation discards the held instruction and all pending busy bits.
- Accept→`out_valid` latency: 1 cycle. Full throughput of 1 instruction/cycle with `out_ready` held high and no hazards.
- A busy bit set by an accept is visible to the hazard check on the next cycle. Back-to-back dependent instructions therefore stall until the matching `wb_valid` cycle, and issue in that cycle via the bypass.
- `in_ready` depends combinationally on `out_ready`, `flush`, `wb_valid`/`wb_rd` and the in_* fields. No combinational path exists from `in_valid` to `in_ready`.
- While `out_valid & ~out_ready`, the out_* fields are stable.

## Test plan
- **Reset:** hold reset_n=0 for 2 cycles with `in_valid=1` → `out_valid=0`, `busy=0`, `stall_count=0`, `in_ready` ignored.
- **Stream, no hazards:** `addi x1`, `addi x2`, `addi x3` back-to-back with `out_ready=1` → `out_valid` high for 3 consecutive cycles starting 1 cycle after the first accept. `busy` = 0x0000000E after the third accept.
- **RAW stall plus bypass:**
  - issue `add x5,…`, then `sub x6,x5,x1`;
  - second instruction stalls (`in_ready=0`, `stall_count` +1 per cycle) until `wb_valid=1, wb_rd=5`;
  - it issues in that same cycle, and `busy[5]`=0, `busy[6]`=1 afterward.
- **WAW plus x0:**
  - `rd=7` pending, then a new instruction with `rd=7` → stalls;
  - an instruction with `rd=0` and `rs1=0` → never stalls, and `busy[0]` stays 0.
- **Backpressure:** `out_ready=0` with the issue register full → `in_ready=0` and the out_* fields stay stable for 4 cycles. Raising `out_ready` accepts the next instruction in the same cycle.
- **Flush:**
  - with `out_valid=1, out_rd=9` not consumed, assert `flush` together with `in_valid=1` and `wb_valid=1, wb_rd=3`;
  - next cycle `out_valid=0`, `busy[9]`=0, `busy[3]`=0, and nothing accepted.
